// File: rtl/io_bus_pkg.sv
// Shared definitions for the device I/O bus: initiator FSM states and the
// device-ID map served by the I/O bus dispatcher.
package io_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RESP
    } bus_state_e;

    localparam logic [31:0] DEV_UART           = 32'h0000_0000;
    localparam logic [31:0] DEV_SPI_DATA       = 32'h0000_0001;
    localparam logic [31:0] DEV_SPI_MODE       = 32'h0000_0002;
    localparam logic [31:0] DEV_SPI_CLKSHAMT   = 32'h0000_0003;
    localparam logic [31:0] DEV_GPOUT          = 32'h0000_0004;
    localparam logic [31:0] DEV_HDMI_COL_MODE  = 32'h0000_0006;
    localparam logic [31:0] DEV_HDMI_COL_TABLE = 32'h0000_0007;
    localparam logic [31:0] DEV_CLK_COUNT_L    = 32'h0000_1000;
    localparam logic [31:0] DEV_CLK_COUNT_H    = 32'h0000_1001;
    localparam logic [31:0] DEV_CLK_FREQ       = 32'h0000_1002;
    localparam logic [31:0] DEV_MS_COUNT_L     = 32'h0000_1003;
    localparam logic [31:0] DEV_MS_COUNT_H     = 32'h0000_1004;
    localparam logic [31:0] DEV_HDMI_VRAM_BASE = 32'h1000_0000;
    localparam logic [31:0] DEV_HDMI_VRAM_LEN  = 32'h0100_0000;

endpackage

// File: rtl/io_watchdog.sv
// Saturating cycle counter that flags a bus access outstanding for
// TimeoutCycles cycles. TimeoutCycles = 0 disables expiry entirely.
module io_watchdog #(
    parameter int unsigned TimeoutCycles = 65535
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned CW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CW-1:0] LastCount = CW'(TimeoutCycles - 1);
    localparam bit Enabled = (TimeoutCycles != 0);

    logic [CW-1:0] r_count;
    logic          w_at_last;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Expiry is seen during the TimeoutCycles-th enabled cycle, so the FSM
    // leaves the strobe state on that cycle's closing edge.
    assign w_at_last = (r_count == LastCount);
    assign o_expired = Enabled && i_enable && w_at_last;

endmodule

// File: rtl/io_bus_initiator.sv
// CPU-side initiator for the device I/O bus: one in/out request at a time,
// strobes held until device handshake or watchdog expiry, then one response.
module io_bus_initiator #(
    parameter int unsigned TimeoutCycles = 65535
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [31:0] i_req_dev_id,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_timeout,
    output logic [31:0] o_dev_id,
    output logic        o_bus_wr_valid,
    output logic [31:0] o_bus_wr_bits,
    input  logic        i_bus_wr_ready,
    output logic        o_bus_rd_ready,
    input  logic        i_bus_rd_valid,
    input  logic [31:0] i_bus_rd_bits
);

    import io_bus_pkg::*;

    bus_state_e  r_state;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_timeout;
    logic [31:0] r_dev_id;
    logic        r_wr_valid;
    logic [31:0] r_wr_bits;
    logic        r_rd_ready;

    logic w_accept;
    logic w_wd_enable;
    logic w_expired;

    assign w_accept    = (r_state == ST_IDLE) && i_req_valid;
    assign w_wd_enable = (r_state == ST_WR) || (r_state == ST_RD);

    io_watchdog #(
        .TimeoutCycles(TimeoutCycles)
    ) u_watchdog (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (w_accept),
        .i_enable (w_wd_enable),
        .o_expired(w_expired)
    );

    // Strobes are registered from the next state so the dispatcher's
    // combinational replies never loop back through this block.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_req_ready    <= 1'b1;
            r_resp_valid   <= 1'b0;
            r_resp_rdata   <= '0;
            r_resp_timeout <= 1'b0;
            r_dev_id       <= '0;
            r_wr_valid     <= 1'b0;
            r_wr_bits      <= '0;
            r_rd_ready     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_dev_id    <= i_req_dev_id;
                        r_wr_bits   <= i_req_wdata;
                        r_req_ready <= 1'b0;
                        if (i_req_write) begin
                            r_state    <= ST_WR;
                            r_wr_valid <= 1'b1;
                        end else begin
                            r_state    <= ST_RD;
                            r_rd_ready <= 1'b1;
                        end
                    end
                end
                ST_WR: begin
                    if (i_bus_wr_ready || w_expired) begin
                        r_state        <= ST_RESP;
                        r_wr_valid     <= 1'b0;
                        r_resp_valid   <= 1'b1;
                        r_resp_rdata   <= '0;
                        r_resp_timeout <= !i_bus_wr_ready;
                    end
                end
                ST_RD: begin
                    if (i_bus_rd_valid) begin
                        r_state        <= ST_RESP;
                        r_rd_ready     <= 1'b0;
                        r_resp_valid   <= 1'b1;
                        r_resp_rdata   <= i_bus_rd_bits;
                        r_resp_timeout <= 1'b0;
                    end else if (w_expired) begin
                        r_state        <= ST_RESP;
                        r_rd_ready     <= 1'b0;
                        r_resp_valid   <= 1'b1;
                        r_resp_rdata   <= '0;
                        r_resp_timeout <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (i_resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_wr_valid   <= 1'b0;
                    r_rd_ready   <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready    = r_req_ready;
    assign o_resp_valid   = r_resp_valid;
    assign o_resp_rdata   = r_resp_rdata;
    assign o_resp_timeout = r_resp_timeout;
    assign o_dev_id       = r_dev_id;
    assign o_bus_wr_valid = r_wr_valid;
    assign o_bus_wr_bits  = r_wr_bits;
    assign o_bus_rd_ready = r_rd_ready;

endmodule

// File: tb/tb_io_bus_initiator.sv
// Directed bench for io_bus_initiator: a scripted device answers each strobe
// after a chosen delay, responses are checked against a queue of expectations.
module tb_io_bus_initiator;

    import io_bus_pkg::*;

    localparam int T = 16;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_write = 1'b0;
    logic [31:0] i_req_dev_id = '0;
    logic [31:0] i_req_wdata = '0;
    logic        o_resp_valid;
    logic        i_resp_ready = 1'b1;
    logic [31:0] o_resp_rdata;
    logic        o_resp_timeout;
    logic [31:0] o_dev_id;
    logic        o_bus_wr_valid;
    logic [31:0] o_bus_wr_bits;
    logic        i_bus_wr_ready = 1'b0;
    logic        o_bus_rd_ready;
    logic        i_bus_rd_valid = 1'b0;
    logic [31:0] i_bus_rd_bits = '0;

    io_bus_initiator #(
        .TimeoutCycles(T)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_write   (i_req_write),
        .i_req_dev_id  (i_req_dev_id),
        .i_req_wdata   (i_req_wdata),
        .o_resp_valid  (o_resp_valid),
        .i_resp_ready  (i_resp_ready),
        .o_resp_rdata  (o_resp_rdata),
        .o_resp_timeout(o_resp_timeout),
        .o_dev_id      (o_dev_id),
        .o_bus_wr_valid(o_bus_wr_valid),
        .o_bus_wr_bits (o_bus_wr_bits),
        .i_bus_wr_ready(i_bus_wr_ready),
        .o_bus_rd_ready(o_bus_rd_ready),
        .i_bus_rd_valid(i_bus_rd_valid),
        .i_bus_rd_bits (i_bus_rd_bits)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] rdata;
        logic        timeout;
        logic [31:0] dev;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Issue one request; the device handshakes in strobe cycle delay+1
    // (delay < 0 means never). Returns strobe-cycle count and response latency.
    task automatic do_req(input string tag, input logic wr, input logic [31:0] dev,
                          input logic [31:0] wdata, input int delay,
                          input logic [31:0] rbits,
                          output int n_strobe, output int n_lat);
        exp_t e;
        bit   hs_ok;
        bit   done;
        bit   hs;
        hs_ok = (delay >= 0) && (delay < T);
        e.rdata   = (wr || !hs_ok) ? 32'h0 : rbits;
        e.timeout = !hs_ok;
        e.dev     = dev;
        exp_q.push_back(e);
        check({tag, ".req_ready"}, {31'b0, o_req_ready}, 32'd1);
        i_req_valid  = 1'b1;
        i_req_write  = wr;
        i_req_dev_id = dev;
        i_req_wdata  = wdata;
        n_strobe = 0;
        n_lat    = 0;
        done     = 1'b0;
        while (!done && n_lat < 60) begin
            @(negedge i_clk);
            i_req_valid = 1'b0;
            n_lat++;
            if (o_bus_wr_valid && o_bus_rd_ready)
                check({tag, ".one_strobe"}, 32'd1, 32'd0);
            if (o_bus_wr_valid || o_bus_rd_ready) begin
                n_strobe++;
                if (o_bus_wr_valid)
                    check({tag, ".wr_bits"}, o_bus_wr_bits, wdata);
                hs = (delay >= 0) && (n_strobe == delay + 1);
                i_bus_wr_ready = hs && wr;
                i_bus_rd_valid = hs && !wr;
                i_bus_rd_bits  = rbits;
            end else begin
                i_bus_wr_ready = 1'b0;
                i_bus_rd_valid = 1'b0;
                i_bus_rd_bits  = '0;
            end
            if (o_resp_valid) done = 1'b1;
        end
        if (!done) begin
            check({tag, ".resp_wait"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".rdata"}, o_resp_rdata, e.rdata);
            check({tag, ".timeout"}, {31'b0, o_resp_timeout}, {31'b0, e.timeout});
            check({tag, ".dev_id"}, o_dev_id, e.dev);
        end
    endtask

    // Response consumed at this negedge's following edge; IDLE must follow.
    task automatic finish_resp(input string tag);
        @(negedge i_clk);
        check({tag, ".ready_again"}, {31'b0, o_req_ready}, 32'd1);
        check({tag, ".resp_dropped"}, {31'b0, o_resp_valid}, 32'd0);
    endtask

    initial begin
        int          ns;
        int          nl;
        int          seen;
        logic [31:0] held;

        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        check("rst.req_ready", {31'b0, o_req_ready}, 32'd1);
        check("rst.resp_valid", {31'b0, o_resp_valid}, 32'd0);
        check("rst.timeout", {31'b0, o_resp_timeout}, 32'd0);
        check("rst.wr_valid", {31'b0, o_bus_wr_valid}, 32'd0);
        check("rst.rd_ready", {31'b0, o_bus_rd_ready}, 32'd0);
        check("rst.rdata", o_resp_rdata, 32'd0);
        check("rst.dev_id", o_dev_id, 32'd0);
        check("rst.wr_bits", o_bus_wr_bits, 32'd0);

        // Write, device ready immediately: 1 strobe cycle, response in N+2.
        do_req("wr_fast", 1'b1, DEV_UART, 32'h41, 0, 32'h0, ns, nl);
        check("wr_fast.strobes", ns, 32'd1);
        check("wr_fast.latency", nl, 32'd2);
        finish_resp("wr_fast");

        // Read with the device answering after 5 cycles.
        do_req("rd_slow", 1'b0, DEV_CLK_FREQ, 32'h0, 5, 32'h00E4_E1C0, ns, nl);
        check("rd_slow.strobes", ns, 32'd6);
        check("rd_slow.latency", nl, 32'd7);
        finish_resp("rd_slow");

        // Unmapped device: strobe for exactly T cycles, then timeout.
        do_req("rd_tmo", 1'b0, 32'h0000_DEAD, 32'h0, -1, 32'hFFFF_FFFF, ns, nl);
        check("rd_tmo.strobes", ns, T);
        check("rd_tmo.latency", nl, T + 1);
        finish_resp("rd_tmo");

        // Write timeout as well.
        do_req("wr_tmo", 1'b1, DEV_SPI_DATA, 32'hA5A5_0001, -1, 32'h0, ns, nl);
        check("wr_tmo.strobes", ns, T);
        finish_resp("wr_tmo");

        // Handshake lands on the expiry cycle: handshake wins.
        do_req("rd_edge", 1'b0, DEV_MS_COUNT_L, 32'h0, T - 1, 32'h1234_5678, ns, nl);
        check("rd_edge.strobes", ns, T);
        finish_resp("rd_edge");

        // Response backpressure for 4 cycles.
        i_resp_ready = 1'b0;
        do_req("bp", 1'b0, DEV_CLK_COUNT_L, 32'h0, 1, 32'hCAFE_0042, ns, nl);
        held = o_resp_rdata;
        repeat (4) begin
            @(negedge i_clk);
            check("bp.resp_valid", {31'b0, o_resp_valid}, 32'd1);
            check("bp.rdata_stable", o_resp_rdata, held);
            check("bp.req_ready", {31'b0, o_req_ready}, 32'd0);
            check("bp.no_strobe", {30'b0, o_bus_wr_valid, o_bus_rd_ready}, 32'd0);
        end
        i_resp_ready = 1'b1;
        finish_resp("bp");

        // Reset in the middle of a read: dropped with no response.
        i_req_valid  = 1'b1;
        i_req_write  = 1'b0;
        i_req_dev_id = DEV_CLK_COUNT_H;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        check("mid_rst.rd_ready", {31'b0, o_bus_rd_ready}, 32'd1);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("mid_rst.strobes", {30'b0, o_bus_wr_valid, o_bus_rd_ready}, 32'd0);
        check("mid_rst.resp_valid", {31'b0, o_resp_valid}, 32'd0);
        check("mid_rst.req_ready", {31'b0, o_req_ready}, 32'd1);
        check("mid_rst.dev_id", o_dev_id, 32'd0);
        seen = 0;
        repeat (T + 4) begin
            @(negedge i_clk);
            if (o_resp_valid || o_bus_rd_ready) seen++;
        end
        check("mid_rst.quiet", seen, 32'd0);

        do_req("post_rst", 1'b1, DEV_GPOUT, 32'h0000_0055, 2, 32'h0, ns, nl);
        check("post_rst.strobes", ns, 32'd3);
        check("post_rst.latency", nl, 32'd4);
        finish_resp("post_rst");

        check("sb.empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_bus_initiator.md
# io_bus_initiator

CPU-side master for the device I/O bus. It accepts one `in`/`out` request at a time from the execute stage and drives the bus device-ID, write channel and read channel. It holds the bus strobe until the addressed device completes the handshake or a watchdog expires, then returns one response (read data or write acknowledge) to the pipeline. It is the initiator counterpart of the I/O bus dispatcher, which acts as responder.

## Interface
- `TimeoutCycles`, default 65535: number of cycles a bus strobe may stay outstanding before the access is aborted. 0 disables the watchdog.
- `i_clk` input 1: single clock.
- `i_rst` input 1: reset, synchronous, active-high.
- `i_req_valid` input 1: pipeline request present.
- `o_req_ready` output 1: request accepted this cycle.
- `i_req_write` input 1: 1 = `out` (write), 0 = `in` (read).
- `i_req_dev_id` input 32: target device ID.
- `i_req_wdata` input 32: write data, ignored for reads.
- `o_resp_valid` output 1: response present.
- `i_resp_ready` input 1: pipeline consumes response.
- `o_resp_rdata` output 32: read data; 0 for writes and for timeouts.
- `o_resp_timeout` output 1: access aborted by the watchdog.
- `o_dev_id` output 32: bus device ID.
- `if_bus_wr` Decoupled(32) sender: `valid`/`bits` out, `ready` in; this is the write channel to the dispatcher.
- `if_bus_rd` Decoupled(32) receiver: `ready` out, `valid`/`bits` in; this is the read channel from the dispatcher.

## Operation
- **States:**
  - IDLE: `o_req_ready` = 1.
  - WR: `if_bus_wr.valid` = 1.
  - RD: `if_bus_rd.ready` = 1.
  - RESP: `o_resp_valid` = 1.
- **IDLE:** on `i_req_valid`, latch `dev_id`, `wdata` and `write`. Go to WR if `write` = 1, otherwise RD. Clear the watchdog.
- **WR:** `if_bus_wr.bits` = latched `wdata`. When `if_bus_wr.ready` = 1, go to RESP with `rdata` = 0 and `timeout` = 0.
- **RD:** when `if_bus_rd.valid` = 1, capture `if_bus_rd.bits` into `rdata` and go to RESP with `timeout` = 0.
- **RESP:** hold `o_resp_*` stable. When `i_resp_ready` = 1, go to IDLE.
- **Strobes:**
  - `if_bus_wr.valid` and `if_bus_rd.ready` are register outputs that depend on state only. Neither may depend combinationally on `ready`/`valid` from the bus, because the dispatcher's responses are combinational functions of these strobes.
  - Never assert both strobes in the same cycle.
- **Device ID:** `o_dev_id` is registered. It is loaded at accept and stays stable until the next accept.
- **Watchdog** (`TimeoutCycles` > 0):
  - The counter increments each cycle in WR/RD.
  - If it reaches `TimeoutCycles` - 1 without a handshake, go to RESP with `timeout` = 1 and `rdata` = 0.
  - If the handshake and expiry happen in the same cycle, the handshake wins and `timeout` = 0.
  - Counter width is `$clog2(TimeoutCycles+1)`. It saturates and does not wrap.
- **Unmapped device:** the dispatcher never handshakes, so the request ends by timeout. With `TimeoutCycles` = 0 it hangs by design.
- **Reset mid-transaction:** the transaction is dropped. No response is produced, and the strobes are low on the cycle after the reset edge.

## Timing
- **Reset values:**
  - state IDLE; `o_req_ready` = 1.
  - `o_resp_valid`, `o_resp_timeout`, `if_bus_wr.valid`, `if_bus_rd.ready` = 0.
  - `o_resp_rdata`, `o_dev_id`, `if_bus_wr.bits` = 0.
- **Minimum latency:**
  - Request accepted at edge N.
  - Strobe high in cycle N+1.
  - If the device responds in the same cycle, response valid in cycle N+2.
  - `o_req_ready` is high again in cycle N+3, provided `i_resp_ready` is high in N+2.
- **Strobe drop:** each strobe drops in the cycle after its handshake, so a device sees exactly one handshake per request.
- **Timeout timing:** the strobe stays high for exactly `TimeoutCycles` cycles, and `o_resp_valid` rises the cycle after.
- **Back-to-back requests:** one request is accepted per 3 cycles at best. There is no overlap and no pipelining.

## Structure
- **Package `io_bus_pkg`:**
  - State enum.
  - Device-ID constants: UART 0x0000, SPI data 0x0001, SPI mode 0x0002, SPI clkshamt 0x0003, GPOUT 0x0004, HDMI col-mode 0x0006, HDMI col-table 0x0007, clk count L/H 0x1000/0x1001, clk freq 0x1002, ms count L/H 0x1003/0x1004, HDMI VRAM base 0x1000_0000 with length 0x0100_0000.
- **Sub-module `io_watchdog`:** clear/enable/expired counter parameterised by `TimeoutCycles`. All other logic is in the top module.

## Test plan
- **Write, device ready immediately:** write 0x41 to dev 0x0000 with `ready` held 1 → `valid` high for 1 cycle with bits 0x41; response in N+2 with `rdata` 0 and `timeout` 0.
- **Read, device delayed:** read dev 0x1002, device `valid` after 5 cycles with bits 0x00E4E1C0 → `rdata` 0x00E4E1C0; `rd.ready` high for exactly 6 cycles.
- **Timeout:** `TimeoutCycles` = 16, read dev 0xDEAD, no response → strobe high 16 cycles, then `timeout` = 1 and `rdata` = 0.
- **Handshake on the expiry cycle:** handshake arrives exactly at the expiry cycle → `timeout` = 0 and data captured.
- **Response backpressure:** `i_resp_ready` = 0 for 4 cycles → response held stable, `o_req_ready` = 0, no new bus strobe.
- **Reset mid-transaction:** `i_rst` pulsed during RD → next cycle all strobes 0 and no response; a following write to 0x0004 completes normally.
